// File: rtl/mem_lane_sequencer.sv
// Load/store lane sequencer: byte enables, lane-aligned store data and extended load data over 1-2 bus beats.
// Define SPLIT_UNALIGNED_EN to allow misaligned accesses, split into two beats when they cross a bus word.
module mem_lane_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [5:0]          req_op,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [31:0]         req_wdata,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                resp_valid,
   output logic                resp_err,
   output logic [31:0]         resp_rdata
);
   localparam int N  = DATA_W / 8;
   localparam int LG = $clog2(N);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RESP, ERR} state_t;
   state_t state_q, state_d;

   logic              accept;
   logic [2:0]        acc_size;
   logic [3:0]        acc_lanes;
   logic              acc_ok;
   logic              acc_we;
   logic              acc_err;
   logic              acc_split;
   logic [LG-1:0]     acc_off;
   logic [2*N-1:0]    acc_mask;
   logic [16*N-1:0]   acc_data;
   logic [16*N-1:0]   acc_wd;

   logic [5:0]        op_q;
   logic [LG-1:0]     off_q;
   logic              we_q;
   logic              split_q;
   logic [ADDR_W-1:0] base_q;
   logic [N-1:0]      be0_q, be1_q;
   logic [DATA_W-1:0] wd0_q, wd1_q;
   logic [16*N-1:0]   rbuf_q;
   logic [31:0]       ld_raw;
   logic [31:0]       ld_ext;

   assign accept = req_valid && (state_q == IDLE);

   always_comb begin
      acc_size  = 3'd0;
      acc_lanes = 4'b0000;
      acc_ok    = 1'b1;
      acc_we    = 1'b0;
      case (req_op)
         OP_LB, OP_LBU: acc_size = 3'd1;
         OP_LH, OP_LHU: acc_size = 3'd2;
         OP_LW:         acc_size = 3'd4;
         OP_SB: begin acc_size = 3'd1; acc_we = 1'b1; end
         OP_SH: begin acc_size = 3'd2; acc_we = 1'b1; end
         OP_SW: begin acc_size = 3'd4; acc_we = 1'b1; end
         default:       acc_ok = 1'b0;
      endcase
      case (acc_size)
         3'd1:    acc_lanes = 4'b0001;
         3'd2:    acc_lanes = 4'b0011;
         3'd4:    acc_lanes = 4'b1111;
         default: acc_lanes = 4'b0000;
      endcase
   end

   assign acc_off  = req_addr[LG-1:0];
   assign acc_mask = {{(2*N-4){1'b0}}, acc_lanes} << acc_off;
   assign acc_data = {{(16*N-32){1'b0}}, req_wdata} << {acc_off, 3'b000};

   // Only enabled lanes of a store carry data; everything else is forced to zero.
   for (genvar gi = 0; gi < 2*N; gi++) begin : g_lane
      assign acc_wd[gi*8 +: 8] = (acc_we && acc_mask[gi]) ? acc_data[gi*8 +: 8] : 8'h00;
   end

`ifdef SPLIT_UNALIGNED_EN
   logic [LG+1:0] acc_span;
   assign acc_span  = (LG+2)'(acc_off) + (LG+2)'(acc_size);
   assign acc_err   = !acc_ok;
   assign acc_split = (acc_span > (LG+2)'(N));
`else
   logic acc_misal;
   assign acc_misal = ((acc_size == 3'd2) && req_addr[0]) ||
                      ((acc_size == 3'd4) && (req_addr[1:0] != 2'b00));
   assign acc_err   = !acc_ok || acc_misal;
   assign acc_split = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= 6'h00;
         off_q   <= '0;
         we_q    <= 1'b0;
         split_q <= 1'b0;
         base_q  <= '0;
         be0_q   <= '0;
         be1_q   <= '0;
         wd0_q   <= '0;
         wd1_q   <= '0;
      end else if (accept) begin
         op_q    <= req_op;
         off_q   <= acc_off;
         we_q    <= acc_we;
         split_q <= acc_split;
         base_q  <= {req_addr[ADDR_W-1:LG], {LG{1'b0}}};
         be0_q   <= acc_mask[N-1:0];
         be1_q   <= acc_mask[2*N-1:N];
         wd0_q   <= acc_wd[DATA_W-1:0];
         wd1_q   <= acc_wd[2*DATA_W-1:DATA_W];
      end
   end

   // Read bytes land in a 2N-byte window so a split load reassembles by a single shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rbuf_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if ((state_q == BEAT0) && mem_ready && be0_q[i])
               rbuf_q[i*8 +: 8] <= mem_rdata[i*8 +: 8];
            if ((state_q == BEAT1) && mem_ready && be1_q[i])
               rbuf_q[(N+i)*8 +: 8] <= mem_rdata[i*8 +: 8];
         end
      end
   end

   assign ld_raw = 32'(rbuf_q >> {off_q, 3'b000});

   always_comb begin
      ld_ext = ld_raw;
      case (op_q)
         OP_LB:   ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
         OP_LBU:  ld_ext = {24'h000000, ld_raw[7:0]};
         OP_LH:   ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
         OP_LHU:  ld_ext = {16'h0000, ld_raw[15:0]};
         default: ld_ext = ld_raw;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = acc_err ? ERR : BEAT0;
         BEAT0:   if (mem_ready) state_d = split_q ? BEAT1 : RESP;
         BEAT1:   if (mem_ready) state_d = RESP;
         RESP:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      mem_valid  = 1'b0;
      mem_addr   = '0;
      mem_we     = 1'b0;
      mem_be     = '0;
      mem_wdata  = '0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;
      case (state_q)
         BEAT0: begin
            mem_valid = 1'b1;
            mem_addr  = base_q;
            mem_we    = we_q;
            mem_be    = be0_q;
            mem_wdata = wd0_q;
         end
         BEAT1: begin
            mem_valid = 1'b1;
            mem_addr  = base_q + ADDR_W'(N);
            mem_we    = we_q;
            mem_be    = be1_q;
            mem_wdata = wd1_q;
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = we_q ? 32'h0 : ld_ext;
         end
         ERR: begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_lane_sequencer.sv
// Scoreboard bench for mem_lane_sequencer: a 32-bit and a 64-bit instance, directed vectors.
module tb_mem_lane_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [5:0]  req_op = 6'h00;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;

   logic        req_valid_a = 1'b0, req_ready_a, mem_valid_a, mem_ready_a = 1'b0, mem_we_a;
   logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a = 32'h0, resp_rdata_a;
   logic [3:0]  mem_be_a;
   logic        resp_valid_a, resp_err_a;

   logic        req_valid_b = 1'b0, req_ready_b, mem_valid_b, mem_ready_b = 1'b0, mem_we_b;
   logic [31:0] mem_addr_b, resp_rdata_b;
   logic [63:0] mem_wdata_b, mem_rdata_b = 64'h0;
   logic [7:0]  mem_be_b;
   logic        resp_valid_b, resp_err_b;

   mem_lane_sequencer #(.DATA_W(32), .ADDR_W(32)) u_a (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_valid(mem_valid_a), .mem_ready(mem_ready_a), .mem_addr(mem_addr_a), .mem_we(mem_we_a),
      .mem_be(mem_be_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
      .resp_valid(resp_valid_a), .resp_err(resp_err_a), .resp_rdata(resp_rdata_a));

   mem_lane_sequencer #(.DATA_W(64), .ADDR_W(32)) u_b (
      .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_valid(mem_valid_b), .mem_ready(mem_ready_b), .mem_addr(mem_addr_b), .mem_we(mem_we_b),
      .mem_be(mem_be_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
      .resp_valid(resp_valid_b), .resp_err(resp_err_b), .resp_rdata(resp_rdata_b));

   typedef struct {logic [31:0] addr; logic [7:0] be; logic we; logic [63:0] wdata;} beat_t;
   typedef struct {logic err; logic [31:0] rdata; int lat;} resp_t;

   beat_t beat_qa[$], beat_qb[$];
   resp_t resp_qa[$], resp_qb[$];
   logic [63:0] rd_qa[$], rd_qb[$];
   int stall_a = 0, stall_b = 0, acc_a = 0, acc_b = 0, cyc = 0;
   int errors = 0, checks = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got event expected none/in-bound", name);
   endtask

   // ---------------- memory responders (drive #1 after the edge) ----------------
   int cnt_a = 0, cnt_b = 0;
   logic hs_prev_a = 1'b0, hs_prev_b = 1'b0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         mem_ready_a = 1'b0; cnt_a = 0; hs_prev_a = 1'b0;
      end else begin
         if (hs_prev_a) begin
            if (rd_qa.size() > 0) void'(rd_qa.pop_front());
            cnt_a = 0;
         end
         if (mem_valid_a && cnt_a >= stall_a) begin
            mem_ready_a = 1'b1;
            mem_rdata_a = (rd_qa.size() > 0) ? rd_qa[0][31:0] : 32'h0;
         end else begin
            mem_ready_a = 1'b0;
            mem_rdata_a = 32'h5A5A5A5A;
            if (mem_valid_a) cnt_a++; else cnt_a = 0;
         end
         hs_prev_a = mem_valid_a && mem_ready_a;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         mem_ready_b = 1'b0; cnt_b = 0; hs_prev_b = 1'b0;
      end else begin
         if (hs_prev_b) begin
            if (rd_qb.size() > 0) void'(rd_qb.pop_front());
            cnt_b = 0;
         end
         if (mem_valid_b && cnt_b >= stall_b) begin
            mem_ready_b = 1'b1;
            mem_rdata_b = (rd_qb.size() > 0) ? rd_qb[0] : 64'h0;
         end else begin
            mem_ready_b = 1'b0;
            mem_rdata_b = 64'h5A5A5A5A5A5A5A5A;
            if (mem_valid_b) cnt_b++; else cnt_b = 0;
         end
         hs_prev_b = mem_valid_b && mem_ready_b;
      end
   end

   // ---------------- monitors (sample on the falling edge) ----------------
   beat_t pa, ea, pb, eb;
   resp_t ra, rb;
   logic pva = 1'b0, pra = 1'b0, pvb = 1'b0, prb = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         pva = 1'b0; pra = 1'b0;
      end else begin
         if (mem_valid_a && pva && !pra)
            chk("a_stall_stable", {mem_addr_a, 4'h0, mem_be_a, mem_we_a, 32'h0, mem_wdata_a},
                {pa.addr, pa.be, pa.we, pa.wdata});
         if (mem_valid_a && mem_ready_a) begin
            if (beat_qa.size() == 0) fail_now("a_unexpected_beat");
            else begin
               ea = beat_qa.pop_front();
               chk("a_beat", {mem_addr_a, 4'h0, mem_be_a, mem_we_a, ea.we ? {32'h0, mem_wdata_a} : 64'h0},
                   {ea.addr, ea.be, ea.we, ea.wdata});
            end
         end
         if (resp_valid_a) begin
            $display("txn a: err=%0d rdata=%h lat=%0d", resp_err_a, resp_rdata_a, cyc - acc_a);
            if (resp_qa.size() == 0) fail_now("a_unexpected_resp");
            else begin
               ra = resp_qa.pop_front();
               chk("a_resp", {resp_err_a, resp_rdata_a, 32'(cyc - acc_a)}, {ra.err, ra.rdata, 32'(ra.lat)});
            end
         end
         pva = mem_valid_a; pra = mem_ready_a;
         pa = '{mem_addr_a, {4'h0, mem_be_a}, mem_we_a, {32'h0, mem_wdata_a}};
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         pvb = 1'b0; prb = 1'b0;
      end else begin
         if (mem_valid_b && pvb && !prb)
            chk("b_stall_stable", {mem_addr_b, mem_be_b, mem_we_b, mem_wdata_b},
                {pb.addr, pb.be, pb.we, pb.wdata});
         if (mem_valid_b && mem_ready_b) begin
            if (beat_qb.size() == 0) fail_now("b_unexpected_beat");
            else begin
               eb = beat_qb.pop_front();
               chk("b_beat", {mem_addr_b, mem_be_b, mem_we_b, eb.we ? mem_wdata_b : 64'h0},
                   {eb.addr, eb.be, eb.we, eb.wdata});
            end
         end
         if (resp_valid_b) begin
            $display("txn b: err=%0d rdata=%h lat=%0d", resp_err_b, resp_rdata_b, cyc - acc_b);
            if (resp_qb.size() == 0) fail_now("b_unexpected_resp");
            else begin
               rb = resp_qb.pop_front();
               chk("b_resp", {resp_err_b, resp_rdata_b, 32'(cyc - acc_b)}, {rb.err, rb.rdata, 32'(rb.lat)});
            end
         end
         pvb = mem_valid_b; prb = mem_ready_b;
         pb = '{mem_addr_b, mem_be_b, mem_we_b, mem_wdata_b};
      end
   end

   // ---------------- stimulus ----------------
   task automatic exp_beat(input bit sel, input logic [31:0] addr, input logic [7:0] be, input logic we,
                           input logic [63:0] wd, input logic [63:0] rd);
      if (sel) begin beat_qb.push_back('{addr, be, we, wd}); rd_qb.push_back(rd); end
      else     begin beat_qa.push_back('{addr, be, we, wd}); rd_qa.push_back(rd); end
   endtask

   task automatic exp_resp(input bit sel, input logic err, input logic [31:0] rdata, input int lat);
      if (sel) resp_qb.push_back('{err, rdata, lat});
      else     resp_qa.push_back('{err, rdata, lat});
   endtask

   task automatic issue(input bit sel, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int stall, input bit wait_done);
      int n;
      @(negedge clk);
      n = 0;
      while (!(sel ? req_ready_b : req_ready_a) && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) fail_now("req_ready_timeout");
      req_op = op; req_addr = addr; req_wdata = wd;
      if (sel) begin stall_b = stall; req_valid_b = 1'b1; end
      else     begin stall_a = stall; req_valid_a = 1'b1; end
      @(posedge clk);
      #1;
      if (sel) begin acc_b = cyc; req_valid_b = 1'b0; end
      else     begin acc_a = cyc; req_valid_a = 1'b0; end
      req_op = 6'h3F; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
      if (wait_done) begin
         n = 0;
         while (!(sel ? req_ready_b : req_ready_a) && n < 100) begin @(negedge clk); n++; end
         if (n >= 100) fail_now("completion_timeout");
      end
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("reset_ready",   {req_ready_a, req_ready_b}, 2'b11);
      chk("reset_mem_a",   {mem_valid_a, mem_we_a, mem_be_a, mem_addr_a, mem_wdata_a}, 70'h0);
      chk("reset_mem_b",   {mem_valid_b, mem_we_b, mem_be_b, mem_addr_b, mem_wdata_b}, 106'h0);
      chk("reset_resp",    {resp_valid_a, resp_err_a, resp_rdata_a, resp_valid_b, resp_err_b, resp_rdata_b}, 68'h0);
      rst = 1'b0;

      exp_beat(0, 32'h1000, 8'h08, 0, 64'h0, 64'h80000000); exp_resp(0, 0, 32'hFFFFFF80, 1);
      issue(0, 6'h20, 32'h1003, 32'h0, 0, 1);
      exp_beat(0, 32'h1000, 8'h08, 0, 64'h0, 64'h80000000); exp_resp(0, 0, 32'h00000080, 1);
      issue(0, 6'h24, 32'h1003, 32'h0, 0, 1);
      exp_beat(0, 32'h2000, 8'h0C, 1, 64'hBEEF0000, 64'h0); exp_resp(0, 0, 32'h0, 4);
      issue(0, 6'h29, 32'h2002, 32'h0000BEEF, 3, 1);
      exp_beat(0, 32'h1000, 8'h02, 1, 64'h0000A500, 64'h0); exp_resp(0, 0, 32'h0, 1);
      issue(0, 6'h28, 32'h1001, 32'hFFFFFFA5, 0, 1);
      exp_beat(0, 32'h1004, 8'h0F, 0, 64'h0, 64'hDEADBEEF); exp_resp(0, 0, 32'hDEADBEEF, 1);
      issue(0, 6'h23, 32'h1004, 32'h0, 0, 1);
      exp_beat(0, 32'h1000, 8'h0C, 0, 64'h0, 64'h80017777); exp_resp(0, 0, 32'hFFFF8001, 1);
      issue(0, 6'h21, 32'h1002, 32'h0, 0, 1);
      exp_beat(0, 32'h1000, 8'h0C, 0, 64'h0, 64'h80017777); exp_resp(0, 0, 32'h00008001, 1);
      issue(0, 6'h25, 32'h1002, 32'h0, 0, 1);
      exp_beat(0, 32'h1008, 8'h0F, 1, 64'hCAFEBABE, 64'h0); exp_resp(0, 0, 32'h0, 3);
      issue(0, 6'h2B, 32'h1008, 32'hCAFEBABE, 2, 1);
      exp_resp(0, 1, 32'h0, 0);
      issue(0, 6'h22, 32'h1000, 32'h12345678, 0, 1);

`ifdef SPLIT_UNALIGNED_EN
      exp_beat(0, 32'h3000, 8'h0E, 1, 64'h22334400, 64'h0);
      exp_beat(0, 32'h3004, 8'h01, 1, 64'h00000011, 64'h0);
      exp_resp(0, 0, 32'h0, 2);
      issue(0, 6'h2B, 32'h3001, 32'h11223344, 0, 1);
      exp_beat(0, 32'h4000, 8'h08, 0, 64'h0, 64'hAABBCCDD);
      exp_beat(0, 32'h4004, 8'h07, 0, 64'h0, 64'h00112233);
      exp_resp(0, 0, 32'h112233AA, 2);
      issue(0, 6'h23, 32'h4003, 32'h0, 0, 1);
      exp_beat(0, 32'h1000, 8'h06, 0, 64'h0, 64'h00CDAB00); exp_resp(0, 0, 32'hFFFFCDAB, 1);
      issue(0, 6'h21, 32'h1001, 32'h0, 0, 1);
      exp_beat(0, 32'h1000, 8'h08, 0, 64'h0, 64'h12000000);
      exp_beat(0, 32'h1004, 8'h01, 0, 64'h0, 64'h00000034);
      exp_resp(0, 0, 32'h00003412, 2);
      issue(0, 6'h25, 32'h1003, 32'h0, 0, 1);
`else
      exp_resp(0, 1, 32'h0, 0);
      issue(0, 6'h2B, 32'h3001, 32'h11223344, 0, 1);
      exp_resp(0, 1, 32'h0, 0);
      issue(0, 6'h23, 32'h4003, 32'h0, 0, 1);
      exp_resp(0, 1, 32'h0, 0);
      issue(0, 6'h21, 32'h1001, 32'h0, 0, 1);
      exp_resp(0, 1, 32'h0, 0);
      issue(0, 6'h25, 32'h1003, 32'h0, 0, 1);
`endif

      exp_beat(1, 32'h5000, 8'hF0, 0, 64'h0, 64'h1122334455667788); exp_resp(1, 0, 32'h11223344, 1);
      issue(1, 6'h23, 32'h5004, 32'h0, 0, 1);
      exp_beat(1, 32'h5008, 8'hF0, 1, 64'hCAFEF00D_00000000, 64'h0); exp_resp(1, 0, 32'h0, 1);
      issue(1, 6'h2B, 32'h500C, 32'hCAFEF00D, 0, 1);
      exp_beat(1, 32'h5000, 8'h80, 0, 64'h0, 64'h7F00000000000000); exp_resp(1, 0, 32'h0000007F, 1);
      issue(1, 6'h20, 32'h5007, 32'h0, 0, 1);
      exp_resp(1, 1, 32'h0, 0);
      issue(1, 6'h00, 32'h5000, 32'h0, 0, 1);

      // abandoned access: no expectation is queued, so any beat or response is flagged
      issue(0, 6'h23, 32'h6000, 32'h0, 1000, 0);
      repeat (3) @(negedge clk);
      chk("stalled_valid", mem_valid_a, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_mem_valid", {mem_valid_a, mem_be_a, mem_addr_a}, 37'h0);
      chk("rst_req_ready", req_ready_a, 1'b1);
      chk("rst_resp_valid", resp_valid_a, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      rd_qa.delete();
      stall_a = 0;
      repeat (4) @(negedge clk);
      exp_beat(0, 32'h6000, 8'h0F, 0, 64'h0, 64'h01020304); exp_resp(0, 0, 32'h01020304, 1);
      issue(0, 6'h23, 32'h6000, 32'h0, 0, 1);

      n = 0;
      while ((beat_qa.size() + resp_qa.size() + beat_qb.size() + resp_qb.size()) != 0 && n < 50) begin
         @(negedge clk); n++;
      end
      chk("pending_expectations", 32'(beat_qa.size() + resp_qa.size() + beat_qb.size() + resp_qb.size()), 32'h0);
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_lane_sequencer.md
# mem_lane_sequencer

Parametrised load/store lane sequencer between the multicycle CPU datapath and the data-memory bus. Accepts one MIPS load/store per request, derives per-beat byte enables from opcode and address, aligns store data onto byte lanes, extracts and sign- or zero-extends load data, and issues one or two bus beats through a valid/ready handshake. Generalises the combinational byte-enable decoder to any power-of-two bus width, with optional splitting of unaligned accesses across two beats.

## Interface

- DATA_W, 32: bus data width; power of two, 32 or 64; N = DATA_W/8 byte lanes.
- ADDR_W, 32: address width.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  6  MIPS opcode; LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- mem_valid  out  1  beat request.
- mem_ready  in  1  beat accepted; read data valid in the same cycle.
- mem_addr  out  ADDR_W  beat address, aligned to N bytes.
- mem_we  out  1  beat is a write.
- mem_be  out  N  byte enables; bit i = lane i = address offset i (little-endian).
- mem_wdata  out  DATA_W  lane-aligned store data.
- mem_rdata  in  DATA_W  read data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; opcode or alignment error.
- resp_rdata  out  32  extended load result; 0 for stores and errors.

## Operation

- Size s: 1 (LB/LBU/SB), 2 (LH/LHU/SH), 4 (LW/SW). Offset o = req_addr mod N.
- Signedness: LBU and LHU zero-extend; LB and LH sign-extend.
- Accept when req_valid && req_ready. Latch op, addr and wdata; later req_* changes are ignored.
- States: IDLE, BEAT0, BEAT1, RESP, ERR.
- Error checks at accept:
  - Unsupported opcode -> ERR.
  - Misalignment (addr mod s != 0) -> ERR when the macro is off; allowed when on.
- Lane masks: mask = ((1<<s)-1) << o over 2N bits; beat0 mem_be = mask[N-1:0]; beat1 mem_be = mask[2N-1:N].
- Store data: wdata << 8*o over 2N bytes; beat0 takes the low N bytes, beat1 the high N bytes.
- Disabled lanes of mem_wdata drive 0. mem_we = 1 for SB/SH/SW.
- BEAT0: mem_addr = addr with the low log2(N) bits cleared.
  - On mem_ready: capture lanes where mem_be = 1, then go to BEAT1 if o+s > N, else RESP.
- BEAT1: mem_addr = beat0 address + N.
  - On mem_ready: capture enabled lanes (upper result bytes), then go to RESP.
- RESP: resp_valid = 1; resp_rdata = assembled, extended value; resp_err = 0; next state IDLE.
- ERR: resp_valid = 1, resp_err = 1, resp_rdata = 0; next state IDLE. No beat is issued.

## Timing

- Reset values:
  - State IDLE; req_ready = 1.
  - mem_valid, mem_we, resp_valid, resp_err = 0.
  - mem_addr, mem_be, mem_wdata, resp_rdata = 0.
- All outputs are registered or decoded from state only. No combinational path from req_* or mem_ready to any output.
- If the accept is at edge T:
  - mem_valid is high from T+1.
  - An aligned beat with mem_ready already high completes at the T+1 edge; resp_valid is then high during T+2.
  - A split access adds one cycle minimum.
  - An error gives resp_valid during T+1.
- While mem_valid && !mem_ready, mem_addr, mem_be, mem_we and mem_wdata hold stable.
- mem_valid drops in the cycle after the final handshake. Beat0 and beat1 are never both presented in the same cycle.
- req_ready is 0 from T+1 until the cycle after resp_valid, so at most one request is in flight.
- Reset mid-access: all outputs return to reset values immediately (asynchronous). The beat is abandoned and no resp_valid is issued.
- mem_ready while mem_valid = 0 is ignored.

## Configuration

- SPLIT_UNALIGNED_EN defined:
  - Non-naturally-aligned LH/LHU/SH/LW/SW are legal.
  - An access that crosses an N-byte boundary runs as two beats through BEAT1.
- Not defined:
  - Any misaligned access goes to ERR.
  - BEAT1 is unreachable and may be removed.
  - Aligned behaviour is identical in both builds.

## Test plan

- DATA_W=32, LB addr 0x1003, mem_rdata 0x80000000.
  - Expect mem_addr 0x1000, mem_be 4'b1000, resp_rdata 0xFFFFFF80.
  - The same stimulus with LBU gives 0x00000080.
- SH addr 0x2002, wdata 0x0000BEEF, mem_ready held low 3 cycles.
  - Expect mem_be 4'b1100, mem_wdata 0xBEEF0000, mem_we 1, all stable while stalled.
  - resp_valid 1 cycle after the handshake.
- SW addr 0x3001, wdata 0x11223344, macro on.
  - Beat0: addr 0x3000, be 4'b1110, wdata 0x22334400.
  - Beat1: addr 0x3004, be 4'b0001, wdata 0x00000011.
  - Macro off: resp_err 1 at T+1, mem_valid never asserted.
- LW addr 0x4003, macro on, beat0 rdata 0xAABBCCDD, beat1 rdata 0x00112233 -> resp_rdata 0x112233AA.
- DATA_W=64, LW addr 0x5004 -> single beat, mem_addr 0x5000, mem_be 8'hF0. Opcode 0x00 -> resp_err 1.
- rst pulsed during a stalled BEAT0.
  - mem_valid 0 and req_ready 1 immediately; no resp_valid.
  - A new LW is then accepted normally.
